id_issue_queue: RTL

Parametrised multi-entry buffer between the decoder and the issue stage. It replaces the single ID/issue pipeline register with a circular queue of `Depth` decoded entries. Up to `NrIssue` entries are presented per cycle in program order. Fetch stays decoupled from issue stalls, and each issue group is limited to one control-flow instruction.

---
 rtl/id_issue_queue_pkg.sv | 52 +++++
 rtl/id_issue_slot_mask.sv | 32 +++
 rtl/id_issue_queue.sv | 113 +++++++++++
 3 files changed

// File: rtl/id_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_issue_queue_pkg
//  Description : Shared constants and types for the ID/issue queue: default
//                queue geometry, the issue-entry payload struct and the
//                pass-through core configuration type.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_issue_queue_pkg;

  // Default queue geometry used when the core instantiates the queue.
  localparam int unsigned IdQueueDepth = 4;
  localparam int unsigned IdNrIssue    = 2;

  // Core configuration carried through the queue untouched.
  typedef struct packed {
    logic [31:0] xlen;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{xlen: 32'd0};

  // Payload as stored in the queue by the core: the decoded scoreboard view
  // plus the original 32-bit instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  fu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] orig_instr;
  } issue_entry_t;

  // Number of slots in a contiguous acknowledge prefix that also hit valid
  // slots; anything after the first gap is not consumed.
  function automatic int unsigned prefix_len(input logic [31:0] ack,
                                             input logic [31:0] valid,
                                             input int unsigned width);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int unsigned k = 0; k < 32; k++) begin
      if (k < width) begin
        run = run & ack[k] & valid[k];
        if (run) n = n + 1;
      end
    end
    return n;
  endfunction

endpackage : id_issue_queue_pkg
`default_nettype wire

// File: rtl/id_issue_slot_mask.sv
`default_nettype none
// ============================================================================
//  Module      : id_issue_slot_mask
//  Description : Slot-validity mask for the issue window. A slot is valid when
//                the queue holds an entry for it and no older slot in the
//                same group is a control-flow instruction, so a branch always
//                closes its issue group.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_issue_slot_mask #(
  parameter int unsigned NrIssue = 2,
  parameter int unsigned CntW    = 3
) (
  input  logic [CntW-1:0]    count_i,
  input  logic [NrIssue-1:0] ctrl_flow_i,
  output logic [NrIssue-1:0] valid_o
);

  logic w_blocked;

  // Walk the slots oldest-first; the first control-flow slot blocks all later ones.
  always_comb begin
    w_blocked = 1'b0;
    valid_o   = '0;
    for (int k = 0; k < int'(NrIssue); k++) begin
      valid_o[k] = (int'(count_i) > k) && !w_blocked;
      w_blocked  = w_blocked | ctrl_flow_i[k];
    end
  end

endmodule : id_issue_slot_mask
`default_nettype wire

// File: rtl/id_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : id_issue_queue
//  Description : Circular queue of decoded entries between decoder and issue.
//                Presents up to NrIssue entries per cycle in program order,
//                limits each issue group to one control-flow instruction and
//                keeps fetch decoupled from issue stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
  parameter int unsigned Depth   = IdQueueDepth,
  parameter int unsigned NrIssue = IdNrIssue,
  parameter type         entry_t = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  entry_t                       fetch_entry_i,
  input  logic                         fetch_is_ctrl_flow_i,
  input  logic                         fetch_entry_valid_i,
  output logic                         fetch_entry_ready_o,
  output entry_t [NrIssue-1:0]         issue_entry_o,
  output logic   [NrIssue-1:0]         is_ctrl_flow_o,
  output logic   [NrIssue-1:0]         issue_entry_valid_o,
  input  logic   [NrIssue-1:0]         issue_instr_ack_i,
  output logic   [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth+1);

  entry_t           r_mem [Depth];
  logic [Depth-1:0] r_ctrl;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic [CW-1:0]    w_pops;

  // Slot k is a pure register read at head + k; the pointer wraps naturally
  // because Depth is a power of two.
  for (genvar k = 0; k < int'(NrIssue); k++) begin : g_slot
    assign issue_entry_o[k]  = r_mem[r_rd_ptr + PW'(k)];
    assign is_ctrl_flow_o[k] = r_ctrl[r_rd_ptr + PW'(k)];
  end

  id_issue_slot_mask #(
    .NrIssue (NrIssue),
    .CntW    (CW)
  ) i_slot_mask (
    .count_i     (r_count),
    .ctrl_flow_i (is_ctrl_flow_o),
    .valid_o     (issue_entry_valid_o)
  );

  // Accepting while full is safe when the head is being consumed this cycle:
  // the new entry lands in the slot the head vacates.
  assign fetch_entry_ready_o = (r_count < CW'(Depth)) || issue_instr_ack_i[0];
  assign w_push              = fetch_entry_ready_o && fetch_entry_valid_i;
  assign count_o             = r_count;

  // Pops are the length of the acknowledged prefix over valid slots only, so
  // a stray ack can never underflow the occupancy.
  always_comb begin
    w_pops = CW'(prefix_len(32'(issue_instr_ack_i), 32'(issue_entry_valid_o), NrIssue));
  end

  // Storage, pointers and occupancy; flush and reset both empty the queue,
  // reset additionally clears storage so every output reads zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
      r_ctrl   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]  <= fetch_entry_i;
        r_ctrl[r_wr_ptr] <= fetch_is_ctrl_flow_i;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= r_rd_ptr + PW'(w_pops);
      r_count  <= r_count + CW'(w_push) - w_pops;
    end
  end

`ifndef SYNTHESIS
  // Acks must form a prefix over valid slots.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      for (int k = 0; k < int'(NrIssue); k++) begin
        if (issue_instr_ack_i[k]) begin
          assert (issue_entry_valid_o[k]);
          if (k > 0) assert (issue_instr_ack_i[k-1]);
        end
      end
    end
  end
`endif

endmodule : id_issue_queue
`default_nettype wire
